mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port, variable-latency memory between the IF stage (instr fetch) and the MEM stage
//  (load/store) of the pipelined mips core. Serialises accesses with a req/ack handshake, gives the MEM stage
//  priority with an anti-starvation override for fetch, and drives per-port stall flags to hold the pipeline.
//  A wait watchdog aborts hung accesses. Sits between mips (instr/read_data/mem_write) and the memory model.
// PARAMETERS
//  AW          32   address width, both ports and memory
//  DW          32   data width
//  TIMEOUT     16   max cycles mem_req may stay high without mem_ack before abort (>=2)
//  STARVE_MAX  3    consecutive DM grants while if_req pending before IF is forced a grant (>=1)
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-low reset
//  if_req     in   1    fetch request; held until if_ready
//  if_addr    in   AW   fetch address (pc_q)
//  if_rdata   out  DW   fetched instruction; valid while if_ready=1
//  if_ready   out  1    1-cycle completion pulse for fetch
//  if_err     out  1    with if_ready: access aborted by watchdog
//  dm_req     in   1    data request; held until dm_ready
//  dm_we      in   1    1 = store, 0 = load
//  dm_addr    in   AW   data address (alu_out)
//  dm_wdata   in   DW   store data (rf_rd2)
//  dm_rdata   out  DW   load data; valid while dm_ready=1
//  dm_ready   out  1    1-cycle completion pulse for data
//  dm_err     out  1    with dm_ready: access aborted by watchdog
//  stall_if   out  1    if_req & ~if_ready (combinational)
//  stall_mem  out  1    dm_req & ~dm_ready (combinational)
//  mem_req    out  1    memory request, registered
//  mem_we     out  1    memory write enable, registered
//  mem_addr   out  AW   registered
//  mem_wdata  out  DW   registered
//  mem_rdata  in   DW   memory read data, sampled with mem_ack
//  mem_ack    in   1    memory completion; only sampled while mem_req=1
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE, all outputs 0, wait_cnt=0, starve_cnt=0; mem_req drops immediately.
//    An in-flight access is abandoned, with no ready pulse.
//  - FSM states: IDLE, BUSY_IF, BUSY_DM.
//  - IDLE: a port is eligible if its req=1 and its ready=0 in this cycle.
//    The ready=0 condition stops re-granting a requester that is still holding req during its ready cycle.
//  - IDLE grant rules:
//    - dm eligible and (starve_cnt<STARVE_MAX or if not eligible): grant DM, next state BUSY_DM.
//    - else if eligible: grant IF, next state BUSY_IF.
//  - On grant edge: mem_req<=1, and addr/we/wdata latch into mem_*. IF grants force mem_we=0 and mem_wdata=0.
//  - BUSY_x: mem_* are held stable and wait_cnt increments each cycle.
//    - mem_ack=1 at an edge: mem_req<=0, x_ready<=1 for one cycle, x_rdata<=mem_rdata (loads and fetches only;
//      stores leave dm_rdata unchanged), wait_cnt<=0, go to IDLE.
//    - wait_cnt==TIMEOUT-1 with mem_ack=0: abort. mem_req<=0, x_ready<=1, x_err<=1, x_rdata unchanged, go to IDLE.
//  - Latency: req seen at edge 0; mem_req=1 from cycle 1; ack sampled at edge k (k>=1); ready/rdata in cycle k+1.
//    Minimum request-to-ready is 2 cycles.
//  - x_err is only ever 1 together with x_ready; both clear the next cycle.
//  - mem_ack while mem_req=0 is ignored.
//  - starve_cnt: +1 on each DM grant while if_req=1, saturating at STARVE_MAX; cleared on any IF grant.
//  - Back-to-back: a new grant is possible in the ready cycle for the *other* port, so IF/DM interleave without
//    idle cycles.
//  - Requests changing addr mid-access are a protocol violation; latched values are used.
// STRUCTURE
//  - Package mips_arb_pkg: arb_state_e (IDLE/BUSY_IF/BUSY_DM), the grant-select encoding and the default
//    TIMEOUT/STARVE_MAX localparams.
//  - Single module, no sub-modules; the watchdog counter and starvation counter are inline.
// TESTING
//  1. Single fetch, if_addr=0x0040_0000, mem acks 1 cycle after mem_req: if_ready pulses 1 cycle later with
//     if_rdata=mem_rdata (0x2008_0005); stall_if=1 until then.
//  2. if_req and dm_req (store, addr 0x10, wdata 0xCAFE) raised together: DM granted first with mem_we=1;
//     IF granted in the dm_ready cycle; no dead cycle.
//  3. if_req held with dm_req re-asserted every cycle, STARVE_MAX=3: grant order DM,DM,DM,IF,DM...; starve_cnt
//     resets to 0 after the IF grant.
//  4. mem_ack never asserted, TIMEOUT=16: mem_req drops after 16 cycles high; dm_ready=1 and dm_err=1 for one
//     cycle; a following access completes normally with err=0.
//  5. reset driven low while BUSY_DM with mem_req=1: mem_req=0 asynchronously; no ready pulse;
//     after release, IDLE with counters 0.
//  6. Spurious mem_ack in IDLE, and dm_req held through its dm_ready cycle: no extra ready pulse and no re-grant
//     of the same request.

Source files
------------

// File: rtl/mips_arb_pkg.sv
// Shared types and default tuning values for the IF/MEM memory arbiter.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } gnt_sel_e;

    localparam int ARB_TIMEOUT_DEF    = 16;
    localparam int ARB_STARVE_MAX_DEF = 3;

    // Data port wins unless fetch has been passed over too often.
    function automatic gnt_sel_e pick_grant(input logic if_elig,
                                            input logic dm_elig,
                                            input logic starved);
        gnt_sel_e sel;
        sel = GNT_NONE;
        if (dm_elig && (!starved || !if_elig)) begin
            sel = GNT_DM;
        end else if (if_elig) begin
            sel = GNT_IF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch
// and load/store, with fetch anti-starvation and a wait watchdog.
module mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = ARB_TIMEOUT_DEF,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          dm_err,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int WCW = $clog2(TIMEOUT);
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    arb_state_e     state;
    logic [WCW-1:0] wait_cnt;
    logic [SCW-1:0] starve_cnt;
    logic           if_elig;
    logic           dm_elig;
    logic           wdog_fire;
    gnt_sel_e       gnt;

    // A port in its ready cycle is not eligible, so a held req is not re-granted.
    assign if_elig   = if_req & ~if_ready;
    assign dm_elig   = dm_req & ~dm_ready;
    assign gnt       = pick_grant(if_elig, dm_elig, starve_cnt >= STARVE_LIM);
    assign wdog_fire = (wait_cnt == WAIT_LAST);

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            if_ready   <= 1'b0;
            if_err     <= 1'b0;
            dm_rdata   <= '0;
            dm_ready   <= 1'b0;
            dm_err     <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            if_err   <= 1'b0;
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;
            case (state)
                IDLE: begin
                    case (gnt)
                        GNT_DM: begin
                            state     <= BUSY_DM;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (if_req && (starve_cnt != STARVE_LIM)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                        GNT_IF: begin
                            state      <= BUSY_IF;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                        default: begin
                        end
                    endcase
                end
                BUSY_IF, BUSY_DM: begin
                    // Ack takes precedence over the watchdog on the same edge.
                    if (mem_ack || wdog_fire) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        if (state == BUSY_IF) begin
                            if_ready <= 1'b1;
                            if_err   <= ~mem_ack;
                            if (mem_ack) begin
                                if_rdata <= mem_rdata;
                            end
                        end else begin
                            dm_ready <= 1'b1;
                            dm_err   <= ~mem_ack;
                            if (mem_ack && !mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-port transactions plus
// hand-written sequences for arbitration, starvation, watchdog and reset.
module tb_mem_arbiter;
    import mips_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_err;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          dm_err;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack   = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_err(dm_err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    bit spur  = 1'b0;
    int acnt  = 0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h0040_0000) ? 32'h2008_0005 : (a ^ 32'hA5A5_0000);
    endfunction

    // Memory model: ack after lat cycles of mem_req (lat=0 never acks).
    always @(negedge clk) begin
        if (mem_req) begin
            acnt    = acnt + 1;
            mem_ack = (lat > 0) && (acnt >= lat);
        end else begin
            acnt    = 0;
            mem_ack = spur;
        end
        mem_rdata = rdata_of(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          port_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];
    vec_t v;
    int   cyc;
    int   n;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         1, 1'b0, 32'h0,         32'h2008_0005, 2};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_1111, 3, 1'b0, 32'h0000_1111, 32'hA5A5_0040, 4};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_CAFE, 2, 1'b1, 32'h0000_CAFE, 32'hA5A5_0040, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0,         5, 1'b0, 32'h0,         32'hA5E5_0004, 6};
        vecs[4] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0,         1, 1'b0, 32'h0,         32'hB791_5678, 2};

        reset = 1'b0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", mem_req, 0);

        // Single-port transactions
        for (int i = 0; i < 5; i++) begin
            v   = vecs[i];
            lat = v.lat;
            if (v.port_dm) begin
                if_req = 0; dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
            end else begin
                dm_req = 0; dm_we = 1; dm_wdata = 32'hFFFF_FFFF; if_req = 1; if_addr = v.addr;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_mem_req", i), mem_req, 1);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, v.addr);
            chk($sformatf("vec%0d_mem_we", i), mem_we, v.exp_we);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, v.exp_wdata);
            chk($sformatf("vec%0d_stall", i), v.port_dm ? stall_mem : stall_if, 1);
            cyc = 1;
            while (!(v.port_dm ? dm_ready : if_ready) && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("vec%0d_latency", i), cyc, v.exp_cyc);
            chk($sformatf("vec%0d_rdata", i), v.port_dm ? dm_rdata : if_rdata, v.exp_rdata);
            chk($sformatf("vec%0d_err", i), v.port_dm ? dm_err : if_err, 0);
            chk($sformatf("vec%0d_stall_rdy", i), v.port_dm ? stall_mem : stall_if, 0);
            if_req = 0; dm_req = 0;
            @(negedge clk);
        end

        // Simultaneous requests: DM store first, IF follows with no dead cycle
        lat = 1;
        if_req = 1; if_addr = 32'h0040_0000;
        dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hCAFE;
        @(negedge clk);
        chk("both_dm_first_addr", mem_addr, 32'h10);
        chk("both_dm_we", mem_we, 1);
        chk("both_dm_wdata", mem_wdata, 32'hCAFE);
        chk("both_stall_if", stall_if, 1);
        @(negedge clk);
        chk("both_dm_ready", dm_ready, 1);
        chk("both_stall_if_hold", stall_if, 1);
        dm_req = 0;
        @(negedge clk);
        chk("both_if_mem_req", mem_req, 1);
        chk("both_if_addr", mem_addr, 32'h0040_0000);
        chk("both_if_we", mem_we, 0);
        @(negedge clk);
        chk("both_if_ready", if_ready, 1);
        chk("both_if_rdata", if_rdata, 32'h2008_0005);
        if_req = 0;
        @(negedge clk);

        // Starvation: three DM grants with fetch pending, then fetch is forced
        dm_we = 0;
        for (int r = 0; r < 3; r++) begin
            if_req = 1; if_addr = 32'h0040_0000;
            dm_req = 1; dm_addr = 32'h20 + 32'(4 * r);
            @(negedge clk);
            chk($sformatf("starve_dm%0d_addr", r), mem_addr, 32'h20 + 32'(4 * r));
            if_req = 0;
            @(negedge clk);
            chk($sformatf("starve_dm%0d_ready", r), dm_ready, 1);
            dm_req = 0;
            @(negedge clk);
        end
        if_req = 1; dm_req = 1; dm_addr = 32'h2C;
        @(negedge clk);
        chk("starve_if_forced", mem_addr, 32'h0040_0000);
        chk("starve_if_we", mem_we, 0);
        @(negedge clk);
        chk("starve_if_ready", if_ready, 1);
        if_req = 0;
        @(negedge clk);
        chk("starve_dm_after_if", mem_addr, 32'h2C);
        chk("starve_dm_after_if_req", mem_req, 1);
        @(negedge clk);
        chk("starve_dm_after_if_rdy", dm_ready, 1);
        dm_req = 0;
        @(negedge clk);
        if_req = 1; dm_req = 1; dm_addr = 32'h30;
        @(negedge clk);
        chk("starve_cleared_dm", mem_addr, 32'h30);
        if_req = 0;
        @(negedge clk);
        chk("starve_cleared_rdata", dm_rdata, 32'hA5A5_0030);
        dm_req = 0;
        @(negedge clk);

        // Spurious ack in IDLE, then a request held through its ready cycle
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("spur_ready", {31'b0, if_ready | dm_ready}, 0);
            chk("spur_mem_req", mem_req, 0);
        end
        spur = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("hold_dm_ready", dm_ready, 1);
        chk("hold_dm_rdata", dm_rdata, 32'hA5A5_0044);
        @(negedge clk);
        chk("hold_no_second_pulse", dm_ready, 0);
        chk("hold_no_regrant", mem_req, 0);
        dm_req = 0;
        @(negedge clk);
        chk("hold_still_idle", mem_req, 0);

        // Watchdog abort, then a normal access
        lat = 0;
        dm_req = 1; dm_addr = 32'h80;
        n = 0;
        @(negedge clk);
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wdog_req_cycles", n, 16);
        chk("wdog_ready", dm_ready, 1);
        chk("wdog_err", dm_err, 1);
        chk("wdog_rdata_kept", dm_rdata, 32'hA5A5_0044);
        dm_req = 0;
        @(negedge clk);
        chk("wdog_ready_clear", dm_ready, 0);
        chk("wdog_err_clear", dm_err, 0);
        lat = 1;
        dm_req = 1; dm_addr = 32'h84;
        @(negedge clk);
        @(negedge clk);
        chk("wdog_next_ready", dm_ready, 1);
        chk("wdog_next_err", dm_err, 0);
        chk("wdog_next_rdata", dm_rdata, 32'hA5A5_0084);
        dm_req = 0;
        @(negedge clk);

        // Asynchronous reset during a hung DM access
        lat = 0;
        dm_req = 1; dm_addr = 32'h90;
        @(negedge clk);
        @(negedge clk);
        chk("arst_busy_req", mem_req, 1);
        #2 reset = 1'b0;
        #1 chk("arst_req_drop", mem_req, 0);
        dm_req = 0;
        @(negedge clk);
        chk("arst_no_ready", dm_ready, 0);
        chk("arst_addr_zero", mem_addr, 0);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("arst_after_no_ready", dm_ready, 0);
            chk("arst_after_no_req", mem_req, 0);
        end
        chk("arst_state_idle", 32'(dut.state), 32'(IDLE));
        chk("arst_wait_cnt", 32'(dut.wait_cnt), 0);
        chk("arst_starve_cnt", 32'(dut.starve_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
